// File: rtl/controlador_detector_pkg.sv
// Shared definitions for the controlador_detector word-to-serial "101" scanner.
// Holds the default parameter values, the controller FSM encoding and the
// detector FSM encoding.
package controlador_detector_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned DEF_TOT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_REPORT = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DET_S0   = 2'd0,
    DET_S1   = 2'd1,
    DET_S10  = 2'd2,
    DET_S101 = 2'd3
  } det_state_e;

endpackage

// File: rtl/controlador_detector_detector.sv
// detector_101_en: overlapping Moore "101" detector with enable and sync clear.
// Ports:
//   clk, rst  - rising-edge clock, async active-high reset (state -> S0)
//   en        - advance on din when 1, hold state when 0
//   clr       - synchronous return to S0, overrides en
//   din       - serial input bit
//   det       - 1 while the detector is in S101
module detector_101_en
  import controlador_detector_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic det
);

  det_state_e state_q, state_d;
  logic       det_q, det_d;

  // Next state; S101 falls back to S1/S10 so overlapping matches are kept.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (en) begin
      case (state_q)
        DET_S0:   state_d = din ? DET_S1   : DET_S0;
        DET_S1:   state_d = din ? DET_S1   : DET_S10;
        DET_S10:  state_d = din ? DET_S101 : DET_S0;
        DET_S101: state_d = din ? DET_S1   : DET_S10;
        default:  state_d = DET_S0;
      endcase
    end
    det_d = (state_d == DET_S101);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DET_S0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
    end
  end

  assign det = det_q;

endmodule

// File: rtl/controlador_detector.sv
// controlador_detector: accepts WIDTH-bit words over valid/ready, shifts them
// MSB-first through a "101" detector, and reports the per-word hit count over
// valid/ready while keeping a wrapping running total of hits.
// Ports:
//   clk, rst              - clock, async active-high reset
//   clear                 - sync clear of total_hits (wins over a same-cycle hit)
//   in_valid/in_ready     - word handshake, in_data scanned bit WIDTH-1 first
//   out_valid/out_ready   - count handshake, out_count held while stalled
//   busy                  - high in SHIFT, FLUSH and REPORT
//   total_hits            - hits since reset/clear, wraps at 2^TOT_W
// Build option: CONTROLADOR_DETECTOR_STREAM_EN keeps detector state across
// word boundaries so a "101" may span two words.
module controlador_detector
  import controlador_detector_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TOT_W = DEF_TOT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready,
  output logic             busy,
  output logic [TOT_W-1:0] total_hits
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic accept;
  logic sample;
  logic hit;
  logic det_en;
  logic det_clr;
  logic det;

  detector_101_en u_det (
    .clk (clk),
    .rst (rst),
    .en  (det_en),
    .clr (det_clr),
    .din (shreg_q[WIDTH-1]),
    .det (det)
  );

  // Sequencing, hit accounting and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    hit_cnt_d   = hit_cnt_q;
    out_count_d = out_count_q;
    total_d     = total_q;
    accept      = 1'b0;
    sample      = 1'b0;
    hit         = 1'b0;
    det_en      = 1'b0;
    det_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          accept    = 1'b1;
          shreg_d   = in_data;
          bit_idx_d = '0;
          hit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_en    = 1'b1;
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_idx_d = bit_idx_q + IDX_W'(1);
        // det lags one cycle, so the first SHIFT cycle has nothing to sample.
        sample    = (bit_idx_q != '0);
        if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Detector held; this picks up the result of the last shifted bit.
        sample  = 1'b1;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hit = sample && det;
    if (hit && (hit_cnt_q != CNT_MAX)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    if (state_q == ST_FLUSH) begin
      out_count_d = hit_cnt_d;
    end
    total_d = clear ? '0 : total_q + TOT_W'(hit);

`ifdef CONTROLADOR_DETECTOR_STREAM_EN
    det_clr = 1'b0;
`else
    det_clr = accept;
`endif

    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      hit_cnt_q   <= '0;
      out_count_q <= '0;
      total_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      out_count_q <= out_count_d;
      total_q     <= total_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign busy       = busy_q;
  assign total_hits = total_q;

endmodule

// File: tb/tb_controlador_detector.sv
// Directed bench for controlador_detector. A second instance with a 4-bit
// total counter runs on the same stimulus so total-counter wrap is reachable
// in a short run.
module tb_controlador_detector;

`ifdef CONTROLADOR_DETECTOR_STREAM_EN
  localparam int unsigned EXP_CROSS = 1;
`else
  localparam int unsigned EXP_CROSS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [3:0]  out_count;
  logic [15:0] total_hits;

  logic        w_in_ready, w_out_valid, w_busy;
  logic [3:0]  w_out_count;
  logic [3:0]  w_total_hits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  controlador_detector dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .out_ready  (out_ready),
    .busy       (busy),
    .total_hits (total_hits)
  );

  controlador_detector #(.TOT_W(4)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (w_in_ready),
    .out_valid  (w_out_valid),
    .out_count  (w_out_count),
    .out_ready  (out_ready),
    .busy       (w_busy),
    .total_hits (w_total_hits)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Present a word in IDLE; returns #1 after the acceptance edge.
  task automatic start_word(input logic [7:0] data);
    check_eq("in_ready before send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    check_eq("out_valid seen", 32'(out_valid), 32'd1);
  endtask

  task automatic run_word(input logic [7:0] data, input int exp_cnt, input string tag);
    int cyc;
    start_word(data);
    wait_out(cyc);
    check_eq({tag, " out_count"}, 32'(out_count), 32'(exp_cnt));
    check_eq({tag, " w_out_count"}, 32'(w_out_count), 32'(exp_cnt));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1;
    do_reset();

    // Reset values
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_count", 32'(out_count), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst total_hits", 32'(total_hits), 32'd0);
    check_eq("rst w_total_hits", 32'(w_total_hits), 32'd0);
    check_eq("rst w_in_ready", 32'(w_in_ready), 32'd1);
    check_eq("rst w_out_valid", 32'(w_out_valid), 32'd0);

    // Isolated 8'hAA: three hits, out_valid nine edges after acceptance
    start_word(8'hAA);
    check_eq("AA busy in shift", 32'(busy), 32'd1);
    check_eq("AA in_ready in shift", 32'(in_ready), 32'd0);
    wait_out(cyc);
    check_eq("AA latency", 32'(cyc), 32'd9);
    check_eq("AA out_count", 32'(out_count), 32'd3);
    check_eq("AA total_hits", 32'(total_hits), 32'd3);
    check_eq("AA busy in report", 32'(busy), 32'd1);
    check_eq("AA w_busy in report", 32'(w_busy), 32'd1);
    step();
    check_eq("AA in_ready after", 32'(in_ready), 32'd1);
    check_eq("AA out_valid after", 32'(out_valid), 32'd0);
    check_eq("AA busy after", 32'(busy), 32'd0);

    // 8'hA5 then 8'hFF
    do_reset();
    run_word(8'hA5, 2, "A5");
    check_eq("A5 total_hits", 32'(total_hits), 32'd2);
    run_word(8'hFF, 0, "FF");
    check_eq("FF total_hits", 32'(total_hits), 32'd2);

    // Backpressure: count held, in_valid ignored
    do_reset();
    out_ready = 1'b0;
    start_word(8'hA5);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      check_eq("bp out_valid", 32'(out_valid), 32'd1);
      check_eq("bp out_count", 32'(out_count), 32'd2);
      check_eq("bp in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("bp release out_valid", 32'(out_valid), 32'd0);
    check_eq("bp release in_ready", 32'(in_ready), 32'd1);
    check_eq("bp total_hits", 32'(total_hits), 32'd2);

    // Sequence spanning a word boundary
    do_reset();
    run_word(8'h01, 0, "x01");
    run_word(8'h40, int'(EXP_CROSS), "x40");
    check_eq("cross total_hits", 32'(total_hits), 32'(EXP_CROSS));

    // Async reset in the third SHIFT cycle
    do_reset();
    run_word(8'hAA, 3, "pre-rst AA");
    start_word(8'hAA);
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("midrst out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst total_hits", 32'(total_hits), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    #2;
    rst = 1'b0;
    step();
    check_eq("postrst out_valid", 32'(out_valid), 32'd0);
    run_word(8'hAA, 3, "postrst AA");
    check_eq("postrst total_hits", 32'(total_hits), 32'd3);

    // Total wrap on the 4-bit instance, then clear coinciding with a hit
    do_reset();
    for (int i = 0; i < 7; i++) run_word(8'hA8, 2, "A8");
    run_word(8'hA0, 1, "A0 to 15");
    check_eq("w_total at 15", 32'(w_total_hits), 32'd15);
    run_word(8'hA0, 1, "A0 wrap");
    check_eq("w_total wrapped", 32'(w_total_hits), 32'd0);
    check_eq("total at 16", 32'(total_hits), 32'd16);
    start_word(8'hAA);
    step();
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_out(cyc);
    check_eq("clr out_count", 32'(out_count), 32'd3);
    check_eq("clr total_hits", 32'(total_hits), 32'd2);
    check_eq("clr w_total_hits", 32'(w_total_hits), 32'd2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_detector.md
Name: controlador_detector

Overview:
- Sequencer that feeds a serial "101" sequence detector from a parallel word source.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first into an embedded enable-gated detector.
- Counts the detections per word, then presents the per-word count downstream over a valid/ready handshake.
- Sits between a parallel producer (UART/bus register) and status logic; also keeps a running total of hits.

Parameters:
- WIDTH, 8: bits per input word; must be >= 3.
- CNT_W, 4: width of the per-word hit count; the count saturates at 2^CNT_W-1.
- TOT_W, 16: width of the running total hit counter; the counter wraps.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high; clears all state.
- clear  in  1  synchronous clear of total_hits only.
- in_valid  in  1  producer has a word.
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is sent first.
- in_ready  out  1  controller can accept a word; high only in IDLE.
- out_valid  out  1  out_count is valid.
- out_count  out  CNT_W  hits found in the last word.
- out_ready  in  1  consumer accepts out_count.
- busy  out  1  high in SHIFT, FLUSH or REPORT.
- total_hits  out  TOT_W  hits since reset or clear, wrapping.

Behaviour:
- Reset values (async on rst): state=IDLE, in_ready=1, out_valid=0, out_count=0, busy=0, total_hits=0, shift register=0, detector state=S0.
- FSM has four states: IDLE, SHIFT, FLUSH, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load in_data into the shift register, bit_idx=0, hit counter=0, go to SHIFT.
  - Without the optional feature, the detector is also cleared to S0 on that edge.
- SHIFT:
  - Detector en=1; din = shreg[WIDTH-1]; shreg shifts left by 1 each cycle.
  - bit_idx increments each cycle. After the cycle with bit_idx=WIDTH-1, go to FLUSH.
- Detector latency:
  - The detector is Moore type, so a hit on the bit shifted in cycle k shows as det=1 in cycle k+1.
  - The controller samples det in SHIFT cycles with bit_idx>=1 and in the single FLUSH cycle.
  - This gives exactly WIDTH samples covering bits 0..WIDTH-1.
- Hit counting: each sampled det=1 increments the hit counter (saturating at 2^CNT_W-1) and increments total_hits (wrapping).
- FLUSH: detector en=0 (state held); take the final sample; latch the count into out_count; go to REPORT.
- REPORT:
  - out_valid=1, and out_count is held stable while out_valid=1 && !out_ready.
  - On out_ready go to IDLE. in_ready only rises in the following cycle; there is no same-cycle turnaround.
- Latency: acceptance edge E0 -> out_valid rises after edge E0+WIDTH+1.
- Throughput: one word per WIDTH+3 cycles when out_ready is held 1.
- clear: sync, zeroes total_hits. If clear coincides with a hit, clear wins; that hit is still counted in out_count.
- in_valid outside IDLE is ignored; in_data is not required to be held after acceptance.
- Reset mid-operation (any state): immediate return to reset values. The partially scanned word is discarded and no out_valid is produced.
- Overlap within a word: detection continues after a hit, so 10101 gives 2 hits.

Optional Feature:
- Macro: CONTROLADOR_DETECTOR_STREAM_EN.
- Defined: the detector state is NOT cleared at word acceptance, so a sequence can span word boundaries. The boundary hit is credited to the word whose bit completes "101".
- Undefined: the detector is forced to S0 on each acceptance edge, so every word is scanned independently.

Decomposition:
- Shared package/header holds:
  - the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, FLUSH=2'd2, REPORT=2'd3);
  - the detector state encodings (S0, S1, S10, S101);
  - the default WIDTH/CNT_W/TOT_W.
- One sub-module, detector_101_en: the 4-state Moore "101" detector with added en (hold state when 0) and sync clr.
  - Async rst, active-high.
  - det=1 only in state S101.

Test Plan:
- Single word, isolated: rst pulse, send 8'hAA (10101010), out_ready=1 -> out_valid after 9 cycles, out_count=3, total_hits=3, in_ready high again 1 cycle later.
- Single word, two hits: send 8'hA5 -> out_count=2. Then send 8'hFF -> out_count=0, total_hits unchanged.
- Backpressure: send 8'hA5, hold out_ready=0 for 5 cycles -> out_valid and out_count=2 stable, in_ready=0 and in_valid ignored throughout. Release -> IDLE next cycle.
- Cross-word sequence: send 8'h01 then 8'h40 -> with STREAM_EN, second out_count=1; without it, second out_count=0.
- Reset during SHIFT (3rd shift cycle): async rst -> out_valid=0, in_ready=1, total_hits=0 immediately. The next word 8'hAA yields out_count=3.
- Clear and wrap: preload total_hits to 16'hFFFF (with TOT_W=16), send 8'hA0 -> total_hits=0. Then assert clear together with a hit on 8'hAA -> total_hits ends at 2, out_count=3.
